// File: rtl/uart_rx_os.sv
// Oversampling UART receiver: synchronises rx, majority-votes three mid-bit samples,
// and presents each word on a valid/ready output register with error and break status.
module uart_rx_os #(
    parameter int DIV_WIDTH   = 16,
    parameter int OS_RATE     = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic [DIV_WIDTH-1:0] divisor,
    input  logic [1:0]           data_size,
    input  logic                 parity_en,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bit_size,
    output logic [7:0]           data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 error_parity,
    output logic                 error_frame,
    output logic                 break_det,
    output logic                 error_overrun,
    output logic                 busy
);

    localparam int PH_W = $clog2(OS_RATE);
    localparam logic [PH_W-1:0] PH_S0   = PH_W'(OS_RATE / 2 - 1);
    localparam logic [PH_W-1:0] PH_S1   = PH_W'(OS_RATE / 2);
    localparam logic [PH_W-1:0] PH_DEC  = PH_W'(OS_RATE / 2 + 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(OS_RATE - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_WAIT_HIGH
    } state_e;

    // Synchroniser and edge history
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxs;
    logic                   rxs_prev_q;

    assign rxs = sync_q[SYNC_STAGES-1];

    // NOTE: every clocked register uses non-blocking assignment so all flops see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q     <= '1;
            rxs_prev_q <= 1'b0;
        end else begin
            sync_q     <= {sync_q[SYNC_STAGES-2:0], rx};
            rxs_prev_q <= rxs;
        end
    end

    // Frame state, counters and per-frame configuration
    state_e                 state_q;
    logic                   busy_q;
    logic [DIV_WIDTH-1:0]   div_q;
    logic [DIV_WIDTH-1:0]   div_cnt_q;
    logic [PH_W-1:0]        phase_q;
    logic [1:0]             size_q;
    logic                   par_en_q;
    logic [1:0]             par_mode_q;
    logic                   stop2_q;
    logic [2:0]             bit_idx_q;
    logic                   stop_idx_q;
    logic [1:0]             samp_q;
    logic [7:0]             shift_q;
    logic                   par_err_q;
    logic                   frm_err_q;
    logic                   brk_q;
    logic                   zero_q;
    logic                   frame_end_q;

    logic tick;
    logic decide;
    logic bit_end;
    logic maj;
    logic xor_all;
    logic par_err_d;

    assign tick    = (div_cnt_q == div_q);
    assign decide  = tick && (phase_q == PH_DEC);
    assign bit_end = tick && (phase_q == PH_LAST);
    assign maj     = (samp_q[0] & samp_q[1]) | (samp_q[0] & rxs) | (samp_q[1] & rxs);
    assign xor_all = (^shift_q) ^ maj;

    // NOTE: a default on the first line of a combinational block keeps every path assigned, so no latch.
    always_comb begin
        par_err_d = 1'b0;
        case (par_mode_q)
            2'b11:   par_err_d = ~xor_all;
            2'b10:   par_err_d = xor_all;
            2'b01:   par_err_d = ~maj;
            default: par_err_d = maj;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
            div_q       <= '0;
            div_cnt_q   <= '0;
            phase_q     <= '0;
            size_q      <= '0;
            par_en_q    <= 1'b0;
            par_mode_q  <= '0;
            stop2_q     <= 1'b0;
            bit_idx_q   <= '0;
            stop_idx_q  <= 1'b0;
            samp_q      <= '0;
            shift_q     <= '0;
            par_err_q   <= 1'b0;
            frm_err_q   <= 1'b0;
            brk_q       <= 1'b0;
            zero_q      <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            frame_end_q <= 1'b0;
            if (tick) begin
                div_cnt_q <= '0;
                phase_q   <= phase_q + PH_W'(1);
            end else begin
                div_cnt_q <= div_cnt_q + DIV_WIDTH'(1);
            end
            if (tick && phase_q == PH_S0) samp_q[0] <= rxs;
            if (tick && phase_q == PH_S1) samp_q[1] <= rxs;

            case (state_q)
                S_IDLE: begin
                    div_cnt_q <= '0;
                    phase_q   <= '0;
                    if (!rxs && rxs_prev_q) begin
                        state_q    <= S_START;
                        busy_q     <= 1'b1;
                        div_q      <= divisor;
                        size_q     <= data_size;
                        par_en_q   <= parity_en;
                        par_mode_q <= parity_mode;
                        stop2_q    <= stop_bit_size;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        shift_q    <= '0;
                        par_err_q  <= 1'b0;
                        frm_err_q  <= 1'b0;
                        brk_q      <= 1'b0;
                        zero_q     <= 1'b1;
                    end
                end
                S_START: begin
                    if (decide && maj) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else if (bit_end) begin
                        state_q <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (decide) begin
                        shift_q[bit_idx_q] <= maj;
                        if (maj) zero_q <= 1'b0;
                    end
                    if (bit_end) begin
                        // last index is 4..7, i.e. {1, data_size}
                        if (bit_idx_q == {1'b1, size_q}) begin
                            state_q <= par_en_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end
                end
                S_PARITY: begin
                    if (decide) begin
                        par_err_q <= par_err_d;
                        if (maj) zero_q <= 1'b0;
                    end
                    if (bit_end) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        if (!maj) frm_err_q <= 1'b1;
                        if (!stop_idx_q) brk_q <= zero_q & ~maj;
                        // The frame ends at the last stop bit's decision, not its end.
                        if (stop_idx_q == stop2_q) begin
                            frame_end_q <= 1'b1;
                            state_q     <= maj ? S_IDLE : S_WAIT_HIGH;
                            busy_q      <= ~maj;
                        end
                    end else if (bit_end) begin
                        stop_idx_q <= 1'b1;
                    end
                end
                S_WAIT_HIGH: begin
                    div_cnt_q <= '0;
                    phase_q   <= '0;
                    if (rxs) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Output register: holds until accepted; a word arriving while full is dropped.
    logic [7:0] data_q;
    logic       valid_q;
    logic       err_par_q;
    logic       err_frm_q;
    logic       brk_out_q;
    logic       ovr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_par_q <= 1'b0;
            err_frm_q <= 1'b0;
            brk_out_q <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            ovr_q <= 1'b0;
            if (frame_end_q) begin
                if (valid_q && !ready) begin
                    ovr_q <= 1'b1;
                end else begin
                    data_q    <= shift_q;
                    err_par_q <= par_err_q;
                    err_frm_q <= frm_err_q;
                    brk_out_q <= brk_q;
                    valid_q   <= 1'b1;
                end
            end else if (valid_q && ready) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data          = data_q;
    assign valid         = valid_q;
    assign error_parity  = err_par_q;
    assign error_frame   = err_frm_q;
    assign break_det     = brk_out_q;
    assign error_overrun = ovr_q;
    assign busy          = busy_q;

endmodule
